// File: rtl/pe_axis_reduce.sv
// pe_axis_reduce: AXI-Stream lane-wise reduction engine.
// Sums BEATS input beats lane by lane (LANES = DATAW/32 unsigned 32-bit lanes)
// and returns a single result beat addressed to RETURN_DEST.
// Build option: define PE_AXIS_REDUCE_SAT_EN to make lane adds saturate at
// 0xFFFFFFFF instead of wrapping modulo 2^32.

// One 32-bit accumulator lane; load starts a packet, add folds in a beat.
module pe_axis_reduce_lane (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        add,
   input  logic [31:0] din,
   output logic [31:0] acc
);
   logic [32:0] sum_w;
   logic [31:0] nxt_w;

   assign sum_w = {1'b0, acc} + {1'b0, din};
`ifdef PE_AXIS_REDUCE_SAT_EN
   // Any carry out pins the lane at all-ones; adding non-negative values
   // afterwards keeps it there until the next load.
   assign nxt_w = sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0];
`else
   logic unused_carry;
   assign unused_carry = sum_w[32];
   assign nxt_w = sum_w[31:0];
`endif

   // Accumulator register: load on first beat, add on following beats.
   always_ff @(posedge clk) begin
      if (reset)     acc <= '0;
      else if (load) acc <= din;
      else if (add)  acc <= nxt_w;
   end
endmodule

module pe_axis_reduce #(
   parameter int DATAW       = 128,
   parameter int DESTW       = 4,
   parameter int BEATS       = 8,
   parameter int RETURN_DEST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             axis_in_tvalid,
   output logic             axis_in_tready,
   input  logic [DATAW-1:0] axis_in_tdata,
   input  logic [DESTW-1:0] axis_in_tdest,
   output logic             axis_out_tvalid,
   input  logic             axis_out_tready,
   output logic [DATAW-1:0] axis_out_tdata,
   output logic [DESTW-1:0] axis_out_tdest
);
   localparam int LANES = DATAW / 32;
   localparam int CW    = $clog2(BEATS + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;

   logic [1:0]                  state;
   logic [CW-1:0]               cnt;
   logic [LANES-1:0][31:0]      acc;
   logic                        in_fire, out_fire, last_beat;
   logic                        unused_dest;

   // Incoming tdest carries no meaning for the reduction.
   assign unused_dest = ^axis_in_tdest;

   // Ready/valid come straight from state so neither side sees a comb path.
   assign axis_in_tready  = (state != SEND);
   assign axis_out_tvalid = (state == SEND);
   assign axis_out_tdata  = (state == SEND) ? acc : '0;
   assign axis_out_tdest  = DESTW'(RETURN_DEST);

   assign in_fire   = axis_in_tvalid & axis_in_tready;
   assign out_fire  = (state == SEND) & axis_out_tready;
   assign last_beat = (cnt == CW'(BEATS - 1));

   // Per-lane accumulators; lanes never carry into one another.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      pe_axis_reduce_lane u_lane (
         .clk   (clk),
         .reset (reset),
         .load  (in_fire && (state == IDLE)),
         .add   (in_fire && (state == ACCUM)),
         .din   (axis_in_tdata[32*i +: 32]),
         .acc   (acc[i])
      );
   end

   // Packet sequencing: count accepted beats, hold the result until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (in_fire) begin
               cnt   <= CW'(1);
               state <= (BEATS == 1) ? SEND : ACCUM;
            end
            ACCUM: if (in_fire) begin
               cnt <= cnt + CW'(1);
               if (last_beat) state <= SEND;
            end
            SEND: if (out_fire) begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pe_axis_reduce.sv
// Bench for pe_axis_reduce (BEATS=4, DATAW=128, RETURN_DEST=0).
// Directed scenarios plus randomized packets against a lane-sum model.
module tb_pe_axis_reduce;
   localparam int DATAW = 128;
   localparam int DESTW = 4;
   localparam int BEATS = 4;
   localparam int LANES = DATAW / 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             axis_in_tvalid;
   logic             axis_in_tready;
   logic [DATAW-1:0] axis_in_tdata;
   logic [DESTW-1:0] axis_in_tdest;
   logic             axis_out_tvalid;
   logic             axis_out_tready;
   logic [DATAW-1:0] axis_out_tdata;
   logic [DESTW-1:0] axis_out_tdest;

   int checks = 0;
   int errors = 0;
   logic [DATAW-1:0] pkt[$];

   always #5 clk = ~clk;

   pe_axis_reduce #(.DATAW(DATAW), .DESTW(DESTW), .BEATS(BEATS), .RETURN_DEST(0)) dut (
      .clk             (clk),
      .reset           (reset),
      .axis_in_tvalid  (axis_in_tvalid),
      .axis_in_tready  (axis_in_tready),
      .axis_in_tdata   (axis_in_tdata),
      .axis_in_tdest   (axis_in_tdest),
      .axis_out_tvalid (axis_out_tvalid),
      .axis_out_tready (axis_out_tready),
      .axis_out_tdata  (axis_out_tdata),
      .axis_out_tdest  (axis_out_tdest)
   );

   task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected result: plain per-lane sum of the packet, wrapped or clamped.
   function automatic logic [DATAW-1:0] model();
      logic [DATAW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         longint unsigned s;
         s = 0;
         foreach (pkt[b]) s += 64'(pkt[b][32*l +: 32]);
`ifdef PE_AXIS_REDUCE_SAT_EN
         if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
         r[32*l +: 32] = s[31:0];
      end
      return r;
   endfunction

   function automatic logic [DATAW-1:0] rnd_beat();
      logic [DATAW-1:0] d;
      for (int l = 0; l < LANES; l++) d[32*l +: 32] = $urandom;
      return d;
   endfunction

   // Present a beat from a negedge; returns at the negedge after it is taken.
   task automatic push(input logic [DATAW-1:0] d, output int waits);
      axis_in_tvalid = 1'b1;
      axis_in_tdata  = d;
      axis_in_tdest  = DESTW'($urandom);
      waits = 0;
      while (axis_in_tready !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 40) chk("push_timeout", DATAW'(axis_in_tready), DATAW'(1));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      axis_in_tvalid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called at the negedge right after the last beat was accepted.
   task automatic check_result(input int stall);
      logic [DATAW-1:0] exp;
      exp = model();
      // Offer junk while the result is pending; it must not be taken.
      axis_in_tvalid = (stall > 0);
      axis_in_tdata  = rnd_beat();
      chk("lat_valid", DATAW'(axis_out_tvalid), DATAW'(1));
      chk("res_data", axis_out_tdata, exp);
      chk("res_dest", DATAW'(axis_out_tdest), DATAW'(0));
      chk("send_in_tready", DATAW'(axis_in_tready), DATAW'(0));
      for (int k = 1; k < stall; k++) begin
         @(negedge clk);
         chk("hold_valid", DATAW'(axis_out_tvalid), DATAW'(1));
         chk("hold_data", axis_out_tdata, exp);
         chk("hold_in_tready", DATAW'(axis_in_tready), DATAW'(0));
      end
      axis_out_tready = 1'b1;
      axis_in_tvalid  = 1'b0;
      @(negedge clk);
      chk("post_valid", DATAW'(axis_out_tvalid), DATAW'(0));
      chk("post_data", axis_out_tdata, '0);
      chk("post_in_tready", DATAW'(axis_in_tready), DATAW'(1));
   endtask

   task automatic send_pkt(input int maxgap, input int stall);
      int w, g;
      axis_out_tready = (stall == 0);
      foreach (pkt[i]) begin
         push(pkt[i], w);
         if (i < BEATS - 1 && maxgap > 0) begin
            g = $urandom_range(0, maxgap);
            if (g > 0) begin
               idle(g);
               chk("no_early_out", DATAW'(axis_out_tvalid), DATAW'(0));
            end
         end
      end
      check_result(stall);
   endtask

   task automatic do_reset();
      axis_in_tvalid = 1'b1;
      axis_in_tdata  = rnd_beat();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      axis_in_tvalid = 1'b0;
      chk("rst_out_valid", DATAW'(axis_out_tvalid), DATAW'(0));
      chk("rst_out_data", axis_out_tdata, '0);
      chk("rst_in_tready", DATAW'(axis_in_tready), DATAW'(1));
   endtask

   function automatic logic [DATAW-1:0] splat(input logic [31:0] v);
      return {LANES{v}};
   endfunction

   initial begin
      int w;
      logic [DATAW-1:0] b;
      reset = 1'b1;
      axis_in_tvalid = 1'b0;
      axis_in_tdata = '0;
      axis_in_tdest = '0;
      axis_out_tready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("init_out_valid", DATAW'(axis_out_tvalid), DATAW'(0));
      chk("init_out_data", axis_out_tdata, '0);
      chk("init_in_tready", DATAW'(axis_in_tready), DATAW'(1));

      // Back-to-back 1,2,3,4 with sink ready, then with a 5-cycle stall.
      pkt = '{splat(1), splat(2), splat(3), splat(4)};
      send_pkt(0, 0);
      send_pkt(0, 5);

      // Lane 0 overflow: wraps to 0x10, or clamps when saturation is built in.
      pkt.delete();
      for (int i = 0; i < BEATS; i++) pkt.push_back(rnd_beat() & ~splat(32'hC000_0000));
      pkt[0][31:0] = 32'hFFFF_FFF0;
      pkt[1][31:0] = 32'h20;
      pkt[2][31:0] = 32'h0;
      pkt[3][31:0] = 32'h0;
      send_pkt(0, 0);

      // Beats on cycles 0, 3, 4, 9.
      pkt.delete();
      for (int i = 0; i < BEATS; i++) pkt.push_back(rnd_beat());
      axis_out_tready = 1'b1;
      push(pkt[0], w);
      idle(2);
      push(pkt[1], w);
      push(pkt[2], w);
      idle(4);
      chk("gap_no_out", DATAW'(axis_out_tvalid), DATAW'(0));
      push(pkt[3], w);
      check_result(0);

      // Reset after two beats discards the partial sum.
      pkt = '{splat(32'h55), splat(32'h66)};
      push(pkt[0], w);
      push(pkt[1], w);
      do_reset();
      pkt = '{splat(1), splat(1), splat(1), splat(1)};
      send_pkt(0, 0);

      // Reset while the result is pending drops it.
      pkt.delete();
      for (int i = 0; i < BEATS; i++) pkt.push_back(rnd_beat());
      axis_out_tready = 1'b0;
      foreach (pkt[i]) push(pkt[i], w);
      chk("pend_valid", DATAW'(axis_out_tvalid), DATAW'(1));
      do_reset();
      axis_out_tready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pend_dropped", DATAW'(axis_out_tvalid), DATAW'(0));
      pkt = '{splat(7), splat(8), splat(9), splat(10)};
      send_pkt(0, 0);

      // Two packets back-to-back: second starts right after the handshake.
      pkt = '{splat(1), splat(1), splat(1), splat(1)};
      axis_out_tready = 1'b1;
      foreach (pkt[i]) push(pkt[i], w);
      chk("b2b_first_valid", DATAW'(axis_out_tvalid), DATAW'(1));
      chk("b2b_first_data", axis_out_tdata, model());
      pkt = '{splat(2), splat(2), splat(2), splat(2)};
      push(pkt[0], w);
      chk("b2b_wait", DATAW'(w), DATAW'(1));
      for (int i = 1; i < BEATS; i++) push(pkt[i], w);
      check_result(0);

      // Randomized packets with gaps and sink stalls.
      for (int p = 0; p < 20; p++) begin
         pkt.delete();
         for (int i = 0; i < BEATS; i++) pkt.push_back(rnd_beat());
         send_pkt(3, $urandom_range(0, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
